// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock divider: board clock rate,
// common half-period counts and the default counter geometry.
package clkdiv_pkg;

    localparam int unsigned BOARD_CLK_HZ     = 100_000_000;
    localparam int unsigned CNT_W_DEF        = 32;

    localparam int unsigned HALF_10KHZ       = 5000;
    localparam int unsigned HALF_1KHZ        = 50_000;
    localparam int unsigned HALF_1HZ         = 50_000_000;

    localparam int unsigned DEFAULT_HALF_DEF = HALF_10KHZ;

    // Half-period count giving a divided clock of hz from the board clock.
    function automatic int unsigned half_for_hz(input int unsigned hz);
        return BOARD_CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active and pending half counts,
// 50% duty output clock and a tick strobe on every toggle.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_half_i,
    output logic             pend_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             term;

    assign term = (cnt_q == half_q - CNT_W'(1));

    always_comb begin
        cnt_d       = cnt_q;
        half_d      = half_q;
        pend_half_d = pend_half_q;
        pend_d      = pend_q;
        clk_d       = clk_q;
        tick_d      = 1'b0;

        if (!en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
                half_d = pend_half_q;
                pend_d = 1'b0;
            end
        end else if (term) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
            // New half only takes over at a toggle, so no phase is cut short.
            if (pend_q) begin
                half_d = pend_half_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A load never coincides with pend_q=1 because ready is gated on it.
        if (load_i) begin
            pend_d      = 1'b1;
            pend_half_d = load_half_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            half_q      <= CNT_W'(DEFAULT_HALF);
            pend_half_q <= '0;
            pend_q      <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
        end
    end

    assign pend_o    = pend_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with a shared valid/ready divisor
// load port; rejected loads (zero half or bad channel) pulse div_err.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
    parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_valid,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_half,
    output logic              div_ready,
    output logic              div_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] load;
    logic              accept;
    logic              bad;
    logic              err_q, err_d;

    // An out-of-range div_ch selects nothing, so it reads as ready and the
    // request completes as a rejection.
    assign div_ready = ~|(sel & pend);
    assign accept    = div_valid && div_ready;
    assign bad       = (div_half == '0) || !(|sel);
    assign err_d     = accept && bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign div_err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign sel[g]  = (div_ch == CH_W'(g));
        assign load[g] = accept && !bad && sel[g];

        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en_i        (en[g]),
            .load_i      (load[g]),
            .load_half_i (div_half),
            .pend_o      (pend[g]),
            .clk_out_o   (clk_out[g]),
            .tick_o      (tick[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: 4 channels, CH_W widened to 3 so
// an out-of-range channel index can be driven.
module tb_clock_divider_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        div_valid;
    logic [2:0]  div_ch;
    logic [31:0] div_half;
    logic        div_ready;
    logic        div_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    int total = 0;
    int bad   = 0;

    clock_divider_multi #(
        .NUM_CH       (4),
        .CNT_W        (32),
        .DEFAULT_HALF (5000),
        .CH_W         (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_valid (div_valid),
        .div_ch    (div_ch),
        .div_half  (div_half),
        .div_ready (div_ready),
        .div_err   (div_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 4'b0000;
        div_valid = 1'b0;
        div_ch    = 3'd0;
        div_half  = 32'd0;

        // Reset state
        step(2);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_err", 32'(div_err), 0);
        chk("rst_ready", 32'(div_ready), 1);

        // Channel 0 at default half 5000: toggle every 5000 cycles
        rst = 1'b0;
        en  = 4'b0001;
        for (int t = 0; t < 4; t++) begin
            step(4999);
            chk("t1_hold_clk", 32'(clk_out[0]), t % 2);
            chk("t1_hold_tick", 32'(tick[0]), 0);
            step(1);
            chk("t1_toggle_clk", 32'(clk_out[0]), (t + 1) % 2);
            chk("t1_toggle_tick", 32'(tick[0]), 1);
            chk("t1_others_clk", 32'(clk_out[3:1]), 0);
            chk("t1_others_tick", 32'(tick[3:1]), 0);
        end
        step(1);
        chk("t1_tick_one_cycle", 32'(tick[0]), 0);

        // Channel 1: load H=3 accepted at cnt=1000 of a 5000 half-period
        en = 4'b0010;
        step(1000);
        div_valid = 1'b1;
        div_ch    = 3'd1;
        div_half  = 32'd3;
        #1;
        chk("t2_ready_before", 32'(div_ready), 1);
        step(1);
        div_valid = 1'b0;
        chk("t2_ready_after_accept", 32'(div_ready), 0);
        step(3998);
        chk("t2_old_hold_clk", 32'(clk_out[1]), 0);
        chk("t2_old_hold_ready", 32'(div_ready), 0);
        step(1);
        chk("t2_apply_clk", 32'(clk_out[1]), 1);
        chk("t2_apply_tick", 32'(tick[1]), 1);
        chk("t2_apply_ready", 32'(div_ready), 1);
        step(2);
        chk("t2_new_hold_clk", 32'(clk_out[1]), 1);
        chk("t2_new_hold_tick", 32'(tick[1]), 0);
        step(1);
        chk("t2_new_toggle1", 32'(clk_out[1]), 0);
        chk("t2_new_tick1", 32'(tick[1]), 1);
        step(2);
        chk("t2_new_hold2", 32'(clk_out[1]), 0);
        step(1);
        chk("t2_new_toggle2", 32'(clk_out[1]), 1);

        // Channel 2: load H=1 while disabled, then enable -> clk/2
        en        = 4'b0000;
        div_valid = 1'b1;
        div_ch    = 3'd2;
        div_half  = 32'd1;
        #1;
        chk("t3_ready_before", 32'(div_ready), 1);
        step(1);
        div_valid = 1'b0;
        chk("t3_ready_pending", 32'(div_ready), 0);
        step(1);
        chk("t3_ready_applied", 32'(div_ready), 1);
        chk("t3_clk_idle", 32'(clk_out[2]), 0);
        en = 4'b0100;
        step(1);
        chk("t3_first_clk", 32'(clk_out[2]), 1);
        chk("t3_first_tick", 32'(tick[2]), 1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t3_div2_clk", 32'(clk_out[2]), (i % 2 == 0) ? 0 : 1);
            chk("t3_div2_tick", 32'(tick[2]), 1);
        end

        // Rejections: zero half to ch0, then out-of-range channel 5
        div_valid = 1'b1;
        div_ch    = 3'd0;
        div_half  = 32'd0;
        #1;
        chk("t4_ready_h0", 32'(div_ready), 1);
        step(1);
        div_valid = 1'b0;
        chk("t4_err_h0", 32'(div_err), 1);
        step(1);
        chk("t4_err_h0_clear", 32'(div_err), 0);
        chk("t4_ch0_no_pending", 32'(div_ready), 1);
        div_valid = 1'b1;
        div_ch    = 3'd5;
        div_half  = 32'd7;
        #1;
        chk("t4_ready_oor", 32'(div_ready), 1);
        step(1);
        div_valid = 1'b0;
        chk("t4_err_oor", 32'(div_err), 1);
        step(1);
        chk("t4_err_oor_clear", 32'(div_err), 0);
        chk("t4_ch2_still_div2", 32'(tick[2]), 1);

        // Channel 3: H=4, then load H=2 accepted on a terminal count
        en        = 4'b0000;
        div_valid = 1'b1;
        div_ch    = 3'd3;
        div_half  = 32'd4;
        step(1);
        div_valid = 1'b0;
        step(1);
        en = 4'b1000;
        step(3);
        chk("t5_hold_clk", 32'(clk_out[3]), 0);
        div_valid = 1'b1;
        div_ch    = 3'd3;
        div_half  = 32'd2;
        #1;
        chk("t5_ready_before", 32'(div_ready), 1);
        step(1);
        div_valid = 1'b0;
        chk("t5_toggle_old_clk", 32'(clk_out[3]), 1);
        chk("t5_toggle_old_tick", 32'(tick[3]), 1);
        chk("t5_ready_pending", 32'(div_ready), 0);
        step(3);
        chk("t5_still_h4_clk", 32'(clk_out[3]), 1);
        chk("t5_still_h4_tick", 32'(tick[3]), 0);
        chk("t5_still_pending", 32'(div_ready), 0);
        step(1);
        chk("t5_apply_clk", 32'(clk_out[3]), 0);
        chk("t5_apply_tick", 32'(tick[3]), 1);
        chk("t5_apply_ready", 32'(div_ready), 1);
        step(1);
        chk("t5_h2_hold_tick", 32'(tick[3]), 0);
        step(1);
        chk("t5_h2_toggle_clk", 32'(clk_out[3]), 1);
        chk("t5_h2_toggle_tick", 32'(tick[3]), 1);

        // Reset with ch0 pending H=7 at cnt=3000 discards the pending value
        en        = 4'b0001;
        div_valid = 1'b1;
        div_ch    = 3'd0;
        div_half  = 32'd7;
        step(1);
        div_valid = 1'b0;
        step(2999);
        chk("t6_pending_before_rst", 32'(div_ready), 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_rst_clk_out", 32'(clk_out), 0);
        chk("t6_rst_tick", 32'(tick), 0);
        chk("t6_rst_err", 32'(div_err), 0);
        chk("t6_rst_ready", 32'(div_ready), 1);
        step(7);
        chk("t6_no_h7_clk", 32'(clk_out[0]), 0);
        chk("t6_no_h7_tick", 32'(tick[0]), 0);
        step(4992);
        chk("t6_default_hold", 32'(clk_out[0]), 0);
        step(1);
        chk("t6_default_toggle_clk", 32'(clk_out[0]), 1);
        chk("t6_default_toggle_tick", 32'(tick[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
